// File: rtl/cache_refill_if.sv
// Load-miss bus between the memory stage, the cache fill port and backing memory.
// The controller takes the slave view; the pipeline/cache/memory side takes the master view.
interface cache_refill_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  read_en;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  stall;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_valid;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  fill_en;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic [DATA_WIDTH-1:0] fill_data;
   logic                  fill_done;

   modport slave (
      input  read_en, hit, addr, mem_valid, mem_rdata,
      output stall, mem_req, mem_addr, fill_en, fill_addr, fill_data, fill_done
   );

   modport master (
      output read_en, hit, addr, mem_valid, mem_rdata,
      input  stall, mem_req, mem_addr, fill_en, fill_addr, fill_data, fill_done
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill controller for a direct-mapped cache.
// It stalls the pipeline, fetches the line one word per beat and writes each word into the cache.
module cache_refill_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic           clk,
   input  logic           rst,
   cache_refill_if.slave  bus
);
   localparam int BEAT_W = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t                state, state_n;
   logic [BEAT_W-1:0]     beat;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic [DATA_WIDTH-1:0] word;
   logic                  miss;
   logic                  accept;

   assign miss      = bus.read_en & ~bus.hit;
   assign accept    = (state == FILL) & bus.mem_valid;
   assign word      = bus.mem_rdata;
   // base has its offset bits cleared, so OR-ing in the beat offset cannot carry out of the line
   assign beat_addr = base | ADDR_WIDTH'({beat, 2'b00});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         beat  <= '0;
         base  <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && miss) begin
            base <= bus.addr & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
            beat <= '0;
         end else if (accept) begin
            beat <= beat + 1'b1;
         end
      end
   end

   always_comb begin
      state_n       = state;
      bus.stall     = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_addr  = '0;
      bus.fill_en   = 1'b0;
      bus.fill_addr = '0;
      bus.fill_data = '0;
      bus.fill_done = 1'b0;
      case (state)
         IDLE: begin
            // the miss stall is combinational, so it is masked to keep outputs low during reset
            bus.stall = miss & ~rst;
            if (miss) state_n = FILL;
         end
         FILL: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = beat_addr;
            if (bus.mem_valid) begin
               bus.fill_en   = 1'b1;
               bus.fill_addr = beat_addr;
               bus.fill_data = word;
               if (beat == BEAT_W'(LINE_WORDS - 1)) state_n = DONE;
            end
         end
         DONE: begin
            bus.fill_done = 1'b1;
            bus.fill_addr = base;
            state_n       = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a vector table for the basic miss plus
// hand sequences for slow memory, mid-burst reset, top-of-memory and back-to-back misses.
module tb_cache_refill_ctrl;
   typedef struct packed {
      logic        stall;
      logic        mem_req;
      logic [31:0] mem_addr;
      logic        fill_en;
      logic [31:0] fill_addr;
      logic [31:0] fill_data;
      logic        fill_done;
   } outs_t;

   typedef struct {
      logic        read_en;
      logic        hit;
      logic [31:0] addr;
      logic        mem_valid;
      logic [31:0] mem_rdata;
      outs_t       exp;
   } vec_t;

   logic  clk;
   logic  rst;
   int    n_cmp;
   int    n_err;
   vec_t  vecs[9];
   outs_t zero;

   cache_refill_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   cache_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before 100000");
      $fatal(1, "watchdog");
   end

   function automatic outs_t mk(input logic s, input logic r, input logic [31:0] ma,
                                input logic fe, input logic [31:0] fa, input logic [31:0] fd,
                                input logic dn);
      outs_t o;
      o.stall = s; o.mem_req = r; o.mem_addr = ma; o.fill_en = fe;
      o.fill_addr = fa; o.fill_data = fd; o.fill_done = dn;
      return o;
   endfunction

   task automatic check(input string name, input outs_t exp, output outs_t act);
      act = mk(bus.stall, bus.mem_req, bus.mem_addr, bus.fill_en,
               bus.fill_addr, bus.fill_data, bus.fill_done);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got stall=%b req=%b maddr=%h fen=%b faddr=%h fdata=%h done=%b, want stall=%b req=%b maddr=%h fen=%b faddr=%h fdata=%h done=%b",
                  name, act.stall, act.mem_req, act.mem_addr, act.fill_en, act.fill_addr,
                  act.fill_data, act.fill_done, exp.stall, exp.mem_req, exp.mem_addr,
                  exp.fill_en, exp.fill_addr, exp.fill_data, exp.fill_done);
      end
   endtask

   // drive one cycle of inputs just after a rising edge, check before the next one
   task automatic step(input logic re, input logic h, input logic [31:0] a, input logic mv,
                       input logic [31:0] rd, input string name, input outs_t exp,
                       output outs_t act);
      bus.read_en = re; bus.hit = h; bus.addr = a; bus.mem_valid = mv; bus.mem_rdata = rd;
      #1;
      check(name, exp, act);
      @(posedge clk);
      #1;
   endtask

   // miss with single-cycle memory: miss cycle, four beats, DONE
   task automatic run_fast_miss(input logic [31:0] a, input logic [31:0] rbase,
                                input logic hold_miss, input string name);
      logic [31:0] b;
      outs_t       act;
      b = a & ~32'hF;
      step(1'b1, 1'b0, a, 1'b0, 32'h0, $sformatf("%s_miss", name),
           mk(1, 0, 0, 0, 0, 0, 0), act);
      for (int unsigned i = 0; i < 4; i++)
         step(1'b1, 1'b0, a, 1'b1, rbase + i, $sformatf("%s_beat%0d", name, i),
              mk(1, 1, b + 4 * i, 1, b + 4 * i, rbase + i, 0), act);
      step(1'b1, ~hold_miss, a, 1'b0, 32'h0, $sformatf("%s_done", name),
           mk(0, 0, 0, 0, b, 0, 1), act);
   endtask

   initial begin
      outs_t act;
      int    stall_cnt;
      int    fen_cnt;
      n_cmp = 0;
      n_err = 0;
      zero  = '0;

      vecs[0] = '{1, 0, 32'h1234, 1, 32'hFF, mk(1, 0, 0, 0, 0, 0, 0)};
      vecs[1] = '{1, 0, 32'h1234, 1, 32'hA0, mk(1, 1, 32'h1230, 1, 32'h1230, 32'hA0, 0)};
      vecs[2] = '{1, 0, 32'h1234, 1, 32'hA1, mk(1, 1, 32'h1234, 1, 32'h1234, 32'hA1, 0)};
      vecs[3] = '{1, 0, 32'h1234, 1, 32'hA2, mk(1, 1, 32'h1238, 1, 32'h1238, 32'hA2, 0)};
      vecs[4] = '{1, 0, 32'h1234, 1, 32'hA3, mk(1, 1, 32'h123C, 1, 32'h123C, 32'hA3, 0)};
      vecs[5] = '{1, 1, 32'h1234, 1, 32'hEE, mk(0, 0, 0, 0, 32'h1230, 0, 1)};
      vecs[6] = '{1, 1, 32'h1234, 1, 32'hEE, mk(0, 0, 0, 0, 0, 0, 0)};
      vecs[7] = '{0, 0, 32'h1234, 0, 32'h0, mk(0, 0, 0, 0, 0, 0, 0)};
      vecs[8] = '{0, 1, 32'h4444, 1, 32'h5, mk(0, 0, 0, 0, 0, 0, 0)};

      rst = 1'b1;
      bus.read_en = 1'b0; bus.hit = 1'b0; bus.addr = '0; bus.mem_valid = 1'b0; bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset", zero, act);
      rst = 1'b0;
      @(posedge clk);
      #1;

      stall_cnt = 0;
      for (int unsigned i = 0; i < 9; i++) begin
         step(vecs[i].read_en, vecs[i].hit, vecs[i].addr, vecs[i].mem_valid, vecs[i].mem_rdata,
              $sformatf("vec%0d", i), vecs[i].exp, act);
         if (act.stall) stall_cnt++;
      end
      n_cmp++;
      if (stall_cnt != 5) begin
         n_err++;
         $display("FAIL fast_stall_cycles: got %0d, want 5", stall_cnt);
      end

      // memory answers only every third cycle
      stall_cnt = 0;
      fen_cnt   = 0;
      for (int unsigned c = 0; c < 15; c++) begin
         logic        mv;
         logic        rq;
         logic [31:0] ma;
         logic [31:0] rd;
         mv = (c >= 1 && c <= 12 && c % 3 == 0);
         rq = (c >= 1 && c <= 12);
         ma = rq ? 32'h1230 + 4 * ((c - 1) / 3) : 32'h0;
         rd = mv ? 32'hB0 + c / 3 - 1 : 32'h0;
         step(1'b1, c >= 13, 32'h1234, mv, rd, $sformatf("slow_c%0d", c),
              mk(c <= 12, rq, ma, mv, mv ? ma : (c == 13 ? 32'h1230 : 32'h0), rd, c == 13), act);
         if (act.stall)   stall_cnt++;
         if (act.fill_en) fen_cnt++;
      end
      n_cmp++;
      if (stall_cnt != 13) begin
         n_err++;
         $display("FAIL slow_stall_cycles: got %0d, want 13", stall_cnt);
      end
      n_cmp++;
      if (fen_cnt != 4) begin
         n_err++;
         $display("FAIL slow_fill_pulses: got %0d, want 4", fen_cnt);
      end

      // reset after the second accepted beat, with a miss and mem_valid still presented
      step(1'b1, 1'b0, 32'h2008, 1'b0, 32'h0, "rst_miss", mk(1, 0, 0, 0, 0, 0, 0), act);
      step(1'b1, 1'b0, 32'h2008, 1'b1, 32'hC0, "rst_beat0",
           mk(1, 1, 32'h2000, 1, 32'h2000, 32'hC0, 0), act);
      step(1'b1, 1'b0, 32'h2008, 1'b1, 32'hC1, "rst_beat1",
           mk(1, 1, 32'h2004, 1, 32'h2004, 32'hC1, 0), act);
      bus.mem_rdata = 32'hC2;
      rst = 1'b1;
      #1;
      check("rst_async", zero, act);
      bus.read_en   = 1'b0;
      bus.mem_valid = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_fast_miss(32'h2008, 32'hD0, 1'b0, "restart");
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "restart_idle", zero, act);

      run_fast_miss(32'hFFFF_FFFF, 32'hE0, 1'b0, "top");
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h77, "top_idle", zero, act);

      // miss held through DONE: DONE lasts one cycle, IDLE catches the miss again
      run_fast_miss(32'h3004, 32'h10, 1'b1, "b2b_a");
      run_fast_miss(32'h3004, 32'h20, 1'b0, "b2b_b");
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "b2b_idle", zero, act);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
